// File: rtl/usb_tx_pkg.sv
// Shared state encoding, PID constants and framing defaults for the USB transmit arbiter.
package usb_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    STREAM,
    DRAIN,
    GAP,
    ERR
  } arb_state_t;

  localparam logic [7:0] PID_ACK   = 8'hD2;
  localparam logic [7:0] PID_NAK   = 8'h5A;
  localparam logic [7:0] PID_STALL = 8'h1E;
  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_DATA1 = 8'h4B;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'h80;

endpackage

// File: rtl/usb_tx_gap_timer.sv
// Loadable down-counter shared by the inter-packet gap countdown and the EOP watchdog.
module usb_tx_gap_timer #(
  parameter int unsigned CNT_W = 12
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count_q;

  // Load wins over decrement; the count parks at zero instead of wrapping.
  always_ff @(posedge clk) begin
    if (n_rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_value;
    end else if (dec && (count_q != '0)) begin
      count_q <= count_q - CNT_W'(1);
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/usb_tx_arbiter.sv
// Arbitrates handshake and data-packet requesters onto the USB transmitter word stream.
// Defining USB_TX_ARB_WDOG_EN adds a watchdog on stalled reads / missing EOP.
module usb_tx_arbiter
  import usb_tx_pkg::*;
#(
  parameter int unsigned LEN_W       = 6,
  parameter int unsigned GAP_CYCLES  = 16,
  parameter int unsigned WDOG_CYCLES = 4096,
  parameter logic [7:0]  SYNC_BYTE   = SYNC_BYTE_DEFAULT
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             hs_req,
  input  logic [7:0]       hs_pid,
  output logic             hs_grant,
  input  logic             dp_req,
  input  logic [7:0]       dp_pid,
  input  logic [LEN_W-1:0] dp_len,
  output logic             dp_grant,
  input  logic [15:0]      dp_data,
  output logic             dp_pop,
  input  logic             tx_read_enable,
  input  logic             tx_error,
  input  logic             eop_seen,
  output logic [15:0]      tx_data,
  output logic             transmit_start,
  output logic             transmit_empty,
  output logic             arb_busy,
  output logic             err_flag
);

  localparam int unsigned CNT_MAX = (WDOG_CYCLES > GAP_CYCLES) ? WDOG_CYCLES : GAP_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] WDOG_LOAD = CNT_W'(WDOG_CYCLES - 1);

`ifdef USB_TX_ARB_WDOG_EN
  localparam bit WDOG_EN = 1'b1;
`else
  localparam bit WDOG_EN = 1'b0;
`endif

  arb_state_t       state_q, state_d;
  logic [LEN_W-1:0] words_left_q;
  logic [15:0]      tx_data_q;
  logic             empty_q;
  logic             err_q;

  logic             timer_load;
  logic [CNT_W-1:0] timer_load_val;
  logic             timer_dec;
  logic             timer_zero;
  logic             wdog_hit;

  usb_tx_gap_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk        (clk),
    .n_rst      (n_rst),
    .load       (timer_load),
    .load_value (timer_load_val),
    .dec        (timer_dec),
    .zero       (timer_zero)
  );

  // Outside GAP the timer only ever runs as the watchdog, so zero means it expired.
  assign wdog_hit = WDOG_EN && timer_zero;

  always_comb begin
    state_d        = state_q;
    hs_grant       = 1'b0;
    dp_grant       = 1'b0;
    dp_pop         = 1'b0;
    timer_load     = 1'b0;
    timer_load_val = GAP_LOAD;
    timer_dec      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (hs_req) begin
          hs_grant = 1'b1;
          state_d  = START;
        end else if (dp_req) begin
          dp_grant = 1'b1;
          state_d  = START;
        end
      end
      START: begin
        timer_load     = WDOG_EN;
        timer_load_val = WDOG_LOAD;
        state_d        = tx_error ? ERR : STREAM;
      end
      STREAM: begin
        if (tx_error || (wdog_hit && !tx_read_enable)) begin
          state_d = ERR;
        end else if (tx_read_enable) begin
          timer_load     = WDOG_EN;
          timer_load_val = WDOG_LOAD;
          if (words_left_q != '0) begin
            dp_pop = 1'b1;
          end else begin
            state_d = DRAIN;
          end
        end else begin
          timer_dec = WDOG_EN;
        end
      end
      DRAIN: begin
        if (tx_error || (wdog_hit && !eop_seen)) begin
          state_d = ERR;
        end else if (eop_seen) begin
          timer_load = 1'b1;
          state_d    = GAP;
        end else begin
          timer_dec = WDOG_EN;
        end
      end
      GAP: begin
        if (tx_error) begin
          state_d = ERR;
        end else if (timer_zero) begin
          state_d = IDLE;
        end else begin
          timer_dec = 1'b1;
        end
      end
      ERR: begin
        // Discard the unsent payload so the source FIFO head lines up with the next packet.
        if (words_left_q != '0) begin
          dp_pop = 1'b1;
        end else begin
          timer_load = 1'b1;
          state_d    = GAP;
        end
      end
      default: state_d = IDLE;
    endcase

    if (n_rst) begin
      hs_grant = 1'b0;
      dp_grant = 1'b0;
      dp_pop   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (n_rst) begin
      state_q      <= IDLE;
      words_left_q <= '0;
      tx_data_q    <= '0;
      empty_q      <= 1'b1;
      err_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      if (hs_grant || dp_grant) begin
        tx_data_q    <= {(hs_grant ? hs_pid : dp_pid), SYNC_BYTE};
        words_left_q <= hs_grant ? '0 : dp_len;
        empty_q      <= 1'b0;
        err_q        <= 1'b0;
      end
      if (dp_pop) begin
        words_left_q <= words_left_q - LEN_W'(1);
        if (state_q == STREAM) begin
          tx_data_q <= dp_data;
        end
      end
      if ((state_q == STREAM) && (state_d == DRAIN)) begin
        empty_q <= 1'b1;
      end
      if ((state_q != ERR) && (state_d == ERR)) begin
        err_q   <= 1'b1;
        empty_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst && dp_pop) begin
      assert (words_left_q != '0);
    end
  end

  assign tx_data        = tx_data_q;
  assign transmit_empty = empty_q;
  assign transmit_start = (state_q == START);
  assign arb_busy       = (state_q != IDLE);
  assign err_flag       = err_q;

endmodule

// File: tb/tb_usb_tx_arbiter.sv
// Self-checking bench for usb_tx_arbiter: directed and randomized packets against a transaction-level model.
// The watchdog scenario is included only when USB_TX_ARB_WDOG_EN is defined.
module tb_usb_tx_arbiter;
  import usb_tx_pkg::*;

  localparam int LEN_W       = 6;
  localparam int GAP_CYCLES  = 16;
  localparam int WDOG_CYCLES = 64;
  localparam logic [7:0] SYNC = 8'h80;

  logic             clk = 1'b0;
  logic             n_rst, hs_req, dp_req, tx_read_enable, tx_error, eop_seen;
  logic             hs_grant, dp_grant, dp_pop, transmit_start, transmit_empty, arb_busy, err_flag;
  logic [7:0]       hs_pid, dp_pid;
  logic [LEN_W-1:0] dp_len;
  logic [15:0]      dp_data, tx_data;

  int   errors = 0;
  int   checks = 0;
  int   pop_cnt = 0;
  int   dp_grant_cnt = 0;
  logic hs_grant_s, dp_grant_s, dp_pop_s;

  logic [15:0] src_fifo[$];
  logic [15:0] payload[$];
  logic [15:0] pending[$];
  logic [7:0]  hs_pids[3] = '{PID_ACK, PID_NAK, PID_STALL};
  logic [7:0]  dp_pids[2] = '{PID_DATA0, PID_DATA1};

  always #5 clk = ~clk;

  usb_tx_arbiter #(
    .LEN_W       (LEN_W),
    .GAP_CYCLES  (GAP_CYCLES),
    .WDOG_CYCLES (WDOG_CYCLES),
    .SYNC_BYTE   (SYNC)
  ) dut (
    .clk            (clk),
    .n_rst          (n_rst),
    .hs_req         (hs_req),
    .hs_pid         (hs_pid),
    .hs_grant       (hs_grant),
    .dp_req         (dp_req),
    .dp_pid         (dp_pid),
    .dp_len         (dp_len),
    .dp_grant       (dp_grant),
    .dp_data        (dp_data),
    .dp_pop         (dp_pop),
    .tx_read_enable (tx_read_enable),
    .tx_error       (tx_error),
    .eop_seen       (eop_seen),
    .tx_data        (tx_data),
    .transmit_start (transmit_start),
    .transmit_empty (transmit_empty),
    .arb_busy       (arb_busy),
    .err_flag       (err_flag)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One clock with the current inputs, called at a negedge; models the source FIFO and clears pulses.
  task automatic applyStimulus();
    dp_data = (src_fifo.size() != 0) ? src_fifo[0] : 16'h0BAD;
    #1;
    hs_grant_s = hs_grant;
    dp_grant_s = dp_grant;
    dp_pop_s   = dp_pop;
    if (dp_grant) dp_grant_cnt++;
    @(posedge clk);
    if (dp_pop_s) begin
      pop_cnt++;
      if (src_fifo.size() != 0) void'(src_fifo.pop_front());
    end
    @(negedge clk);
    tx_read_enable = 1'b0;
    tx_error       = 1'b0;
    eop_seen       = 1'b0;
  endtask

  task automatic pushWord(input logic [15:0] w);
    src_fifo.push_back(w);
    payload.push_back(w);
  endtask

  task automatic loadPayload(input int len);
    payload.delete();
    for (int i = 0; i < len; i++) pushWord(16'($urandom));
  endtask

  task automatic grantRequest(input bit is_hs, input logic [7:0] pid);
    if (is_hs) begin
      hs_req = 1'b1;
      hs_pid = pid;
    end else begin
      dp_req = 1'b1;
      dp_pid = pid;
      dp_len = LEN_W'(payload.size());
    end
    applyStimulus();
    checkOutput(is_hs ? "hs_grant" : "dp_grant", is_hs ? hs_grant_s : dp_grant_s, 1);
    checkOutput("grant_exclusive", is_hs ? dp_grant_s : hs_grant_s, 0);
    checkOutput("grant_clears_err", err_flag, 0);
    hs_req = 1'b0;
    dp_req = 1'b0;
    hs_pid = 8'($urandom);
    dp_pid = 8'($urandom);
    dp_len = LEN_W'($urandom);
  endtask

  // exp_cycles < 0 only bounds the wait; otherwise the busy time must match exactly.
  task automatic waitIdle(input string tag, input int exp_cycles);
    int n;
    int pops0;
    n = 0;
    pops0 = pop_cnt;
    while (arb_busy === 1'b1 && n < 200) begin
      if (exp_cycles >= 0) begin
        tx_read_enable = 1'($urandom_range(0, 1));
        eop_seen       = 1'($urandom_range(0, 1));
      end
      applyStimulus();
      n++;
    end
    if (exp_cycles >= 0) begin
      checkOutput(tag, n, exp_cycles);
      checkOutput("gap_no_pop", pop_cnt - pops0, 0);
    end else begin
      checkOutput(tag, (n < 200), 1);
    end
  endtask

  // Acts as the transmitter for one granted packet; err_at is the read count before tx_error, -1 for none.
  task automatic servePacket(input logic [7:0] pid, input int err_at);
    int pops0, fifo0, n;
    logic [15:0] expw;
    pops0 = pop_cnt;
    fifo0 = src_fifo.size();
    n     = payload.size();
    checkOutput("start_pulse", transmit_start, 1);
    checkOutput("start_word", tx_data, {pid, SYNC});
    checkOutput("start_empty", transmit_empty, 0);
    applyStimulus();
    for (int i = 0; i <= n; i++) begin
      if (i == err_at) begin
        tx_error = 1'b1;
        applyStimulus();
        checkOutput("err_flag_set", err_flag, 1);
        checkOutput("err_empty", transmit_empty, 1);
        for (int k = 0; k < n - i; k++) begin
          applyStimulus();
          checkOutput("flush_pop", dp_pop_s, 1);
        end
        waitIdle("err_recover", -1);
        checkOutput("err_flag_sticky", err_flag, 1);
        checkOutput("err_pop_total", pop_cnt - pops0, n);
        checkOutput("fifo_aligned", src_fifo.size(), fifo0 - n);
        return;
      end
      repeat ($urandom_range(0, 2)) begin
        eop_seen = 1'($urandom_range(0, 1));
        applyStimulus();
      end
      expw = (i == 0) ? {pid, SYNC} : payload[i-1];
      checkOutput("tx_word", tx_data, expw);
      checkOutput("empty_low", transmit_empty, 0);
      tx_read_enable = 1'b1;
      applyStimulus();
    end
    checkOutput("empty_high", transmit_empty, 1);
    checkOutput("pop_count", pop_cnt - pops0, n);
    checkOutput("fifo_aligned", src_fifo.size(), fifo0 - n);
    repeat ($urandom_range(0, 3)) applyStimulus();
    checkOutput("drain_hold", arb_busy, 1);
    eop_seen = 1'b1;
    applyStimulus();
    waitIdle("gap_len", GAP_CYCLES);
  endtask

  initial begin
    bit          is_hs;
    int          rlen, err_at, g0;
    logic [7:0]  pid;
`ifdef USB_TX_ARB_WDOG_EN
    int          n;
`endif

    n_rst = 1'b1;
    hs_req = 1'b1;
    dp_req = 1'b1;
    hs_pid = PID_ACK;
    dp_pid = PID_DATA0;
    dp_len = '0;
    tx_read_enable = 1'b1;
    tx_error = 1'b0;
    eop_seen = 1'b0;
    dp_data = '0;
    @(negedge clk);
    applyStimulus();
    checkOutput("rst_hs_grant", hs_grant_s, 0);
    checkOutput("rst_dp_grant", dp_grant_s, 0);
    checkOutput("rst_dp_pop", dp_pop_s, 0);
    hs_req = 1'b0;
    dp_req = 1'b0;
    applyStimulus();
    n_rst = 1'b0;
    checkOutput("rst_tx_data", tx_data, 0);
    checkOutput("rst_empty", transmit_empty, 1);
    checkOutput("rst_start", transmit_start, 0);
    checkOutput("rst_busy", arb_busy, 0);
    checkOutput("rst_err", err_flag, 0);

    $display("[TB] handshake ACK");
    payload.delete();
    grantRequest(1'b1, PID_ACK);
    servePacket(PID_ACK, -1);

    $display("[TB] DATA0 with three words");
    payload.delete();
    pushWord(16'hA1A1);
    pushWord(16'hB2B2);
    pushWord(16'hC3C3);
    grantRequest(1'b0, PID_DATA0);
    servePacket(PID_DATA0, -1);

    $display("[TB] simultaneous requests");
    loadPayload(2);
    pending = payload;
    payload.delete();
    hs_req = 1'b1;
    hs_pid = PID_NAK;
    dp_req = 1'b1;
    dp_pid = PID_DATA1;
    dp_len = LEN_W'(2);
    applyStimulus();
    checkOutput("both_hs_first", hs_grant_s, 1);
    checkOutput("both_dp_held", dp_grant_s, 0);
    hs_req = 1'b0;
    g0 = dp_grant_cnt;
    servePacket(PID_NAK, -1);
    checkOutput("dp_wait_gap", dp_grant_cnt - g0, 0);
    applyStimulus();
    checkOutput("dp_after_gap", dp_grant_s, 1);
    dp_req = 1'b0;
    payload = pending;
    servePacket(PID_DATA1, -1);

    $display("[TB] tx_error after two reads");
    loadPayload(5);
    grantRequest(1'b0, PID_DATA0);
    servePacket(PID_DATA0, 2);

    $display("[TB] reset mid-stream");
    loadPayload(4);
    grantRequest(1'b0, PID_DATA0);
    applyStimulus();
    tx_read_enable = 1'b1;
    applyStimulus();
    n_rst = 1'b1;
    tx_read_enable = 1'b1;
    hs_req = 1'b1;
    dp_req = 1'b1;
    applyStimulus();
    checkOutput("midrst_no_pop", dp_pop_s, 0);
    checkOutput("midrst_no_grant", hs_grant_s | dp_grant_s, 0);
    n_rst = 1'b0;
    hs_req = 1'b0;
    dp_req = 1'b0;
    checkOutput("midrst_tx_data", tx_data, 0);
    checkOutput("midrst_empty", transmit_empty, 1);
    checkOutput("midrst_busy", arb_busy, 0);
    checkOutput("midrst_start", transmit_start, 0);
    src_fifo.delete();
    payload.delete();
    grantRequest(1'b1, PID_STALL);
    servePacket(PID_STALL, -1);

    $display("[TB] boundary lengths");
    loadPayload(0);
    grantRequest(1'b0, PID_DATA1);
    servePacket(PID_DATA1, -1);
    loadPayload(63);
    grantRequest(1'b0, PID_DATA0);
    servePacket(PID_DATA0, -1);

    $display("[TB] randomized packets");
    for (int p = 0; p < 12; p++) begin
      is_hs  = 1'($urandom_range(0, 1));
      rlen   = is_hs ? 0 : int'($urandom_range(0, 6));
      err_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, rlen)) : -1;
      pid    = is_hs ? hs_pids[$urandom_range(0, 2)] : dp_pids[$urandom_range(0, 1)];
      loadPayload(rlen);
      grantRequest(is_hs, pid);
      servePacket(pid, err_at);
    end

`ifdef USB_TX_ARB_WDOG_EN
    $display("[TB] watchdog with EOP withheld");
    loadPayload(0);
    grantRequest(1'b0, PID_DATA0);
    applyStimulus();
    tx_read_enable = 1'b1;
    applyStimulus();
    n = 0;
    while (err_flag !== 1'b1 && n < 200) begin
      applyStimulus();
      n++;
    end
    checkOutput("wdog_cycles", n, WDOG_CYCLES);
    waitIdle("wdog_recover", -1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/usb_tx_arbiter.md
Name: usb_tx_arbiter

Overview:
- Schedules and arbitrates access to the USB transmit datapath (the transmitter top level with its shift register, CRC, encoder and controller) between two requesters: a handshake requester (ACK/NAK/STALL, PID only) and a data-packet requester (PID plus N 16-bit payload words).
- Builds the word stream the transmitter consumes, drives transmit_start and transmit_empty, and services its read_enable.
- Enforces a post-EOP inter-packet gap and handles tx_error.

Parameters:
- LEN_W, 6, width of the payload word count (max 63 words per packet).
- GAP_CYCLES, 16, idle cycles enforced after EOP before the next grant.
- WDOG_CYCLES, 4096, EOP watchdog limit (only with the optional feature).
- SYNC_BYTE, 8'h80, low byte of the first word of every packet.

Ports:
- clk  in  1  system clock.
- n_rst  in  1  reset; one clock; reset is synchronous and active-high.
- hs_req  in  1  handshake request; level, held until hs_grant.
- hs_pid  in  8  handshake PID; sampled on the grant cycle.
- hs_grant  out  1  one-cycle pulse; the handshake has been accepted.
- dp_req  in  1  data-packet request; level, held until dp_grant.
- dp_pid  in  8  data PID (DATA0/DATA1); sampled on the grant cycle.
- dp_len  in  LEN_W  payload word count (0 allowed); sampled on the grant cycle.
- dp_grant  out  1  one-cycle pulse; the data packet has been accepted.
- dp_data  in  16  payload word at the head of the source FIFO.
- dp_pop  out  1  pops one payload word from the source FIFO.
- tx_read_enable  in  1  from the transmitter; consumes the current tx_data.
- tx_error  in  1  from the transmitter; error pulse.
- eop_seen  in  1  from the line monitor; one-cycle pulse when the line returns to J after EOP.
- tx_data  out  16  word presented to the transmitter.
- transmit_start  out  1  one-cycle pulse that starts a packet.
- transmit_empty  out  1  high when no further word is available.
- arb_busy  out  1  high in every state except IDLE.
- err_flag  out  1  sticky error indicator; cleared on the next grant.

Behaviour:
Reset and outputs:
- Reset values: all outputs 0, except transmit_empty=1.
- State resets to IDLE and all counters clear.
- Reset mid-packet abandons the packet. No dp_pop is issued during or after reset.

States: IDLE, START, STREAM, DRAIN, GAP, ERR.

IDLE:
- If hs_req: pulse hs_grant, latch hs_pid, set words_left=0, go to START.
- Else if dp_req: pulse dp_grant, latch dp_pid and dp_len into words_left, go to START.
- Handshakes have strict priority; when both requests are high in the same cycle, only hs_grant pulses.
- The grant is combinational from IDLE; the latched values are registered.

START (1 cycle):
- tx_data={pid, SYNC_BYTE}, transmit_empty=0, transmit_start=1. Go to STREAM.

STREAM:
- tx_data is held stable until tx_read_enable.
- On tx_read_enable with words_left>0: tx_data<=dp_data, dp_pop=1 in that same cycle, words_left decrements.
- On tx_read_enable with words_left==0: transmit_empty<=1, go to DRAIN.
- Latency from tx_read_enable to the new tx_data is one cycle.
- dp_len=0 results in a PID-only data packet; the CRC is still appended by the transmitter.

DRAIN:
- Wait for eop_seen, then go to GAP with the gap counter loaded to GAP_CYCLES-1.

GAP:
- Count down to 0, then return to IDLE. No grants are issued in GAP.

Error handling:
- tx_error in any non-IDLE state goes to ERR.
- ERR sets err_flag and transmit_empty=1.
- ERR pops and discards the remaining words_left words at one per cycle, so the source FIFO stays aligned, then goes to GAP.

Other rules:
- tx_read_enable in IDLE or GAP is ignored.
- eop_seen outside DRAIN is ignored.
- words_left never wraps; a decrement at 0 is impossible by construction and is flagged by an assertion.

Optional Feature:
- Macro: USB_TX_ARB_WDOG_EN.
- With the macro: a counter runs in STREAM and DRAIN and is reset on each tx_read_enable or eop_seen. On reaching WDOG_CYCLES the block goes to ERR (same flushing as tx_error) and err_flag is set.
- Without the macro: no counter exists and the block waits indefinitely in STREAM and DRAIN.

Decomposition:
- Package usb_tx_pkg holds:
  - the state enum arb_state_t;
  - PID constants (PID_ACK=8'hD2, PID_NAK=8'h5A, PID_STALL=8'h1E, PID_DATA0=8'hC3, PID_DATA1=8'h4B);
  - SYNC_BYTE default.
- One natural sub-module, usb_tx_gap_timer: the down-counter shared by the GAP countdown and the watchdog.

Test Plan:
1. hs_req=1, hs_pid=8'hD2 -> hs_grant pulse, next cycle transmit_start with tx_data=16'hD280; first tx_read_enable -> transmit_empty=1; eop_seen -> arb_busy stays high 16 more cycles, then drops.
2. dp_req, dp_pid=8'hC3, dp_len=3, FIFO holds A1A1/B2B2/C3C3 -> tx_data sequence C380, A1A1, B2B2, C3C3; exactly 3 dp_pop; transmit_empty rises on the 4th tx_read_enable.
3. hs_req and dp_req rise in the same cycle -> handshake sent first; dp_grant only after GAP completes.
4. dp_len=5, tx_error after 2 reads -> ERR; err_flag=1; 3 further dp_pop back-to-back; returns to IDLE after GAP.
5. Synchronous n_rst=1 mid-STREAM -> next cycle all outputs at reset values and transmit_empty=1; a new request is granted normally afterwards.
6. With USB_TX_ARB_WDOG_EN and WDOG_CYCLES=64, eop_seen withheld in DRAIN -> ERR after 64 cycles with err_flag=1.
